munoc_axi_protocol_checker: RTL and testbench

MUNOC_AXI_PROTOCOL_CHECKER -- requirements
Module: munoc_axi_protocol_checker

---
 rtl/munoc_axi_protocol_checker_pkg.sv | 33 +++
 rtl/munoc_axi_len_tracker.sv | 73 +++++++
 rtl/munoc_axi_protocol_checker.sv | 187 ++++++++++++++++++
 tb/tb_munoc_axi_protocol_checker.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/munoc_axi_protocol_checker_pkg.sv
// Shared definitions for the MUNOC AXI protocol checker.
// Contents: error flag bit map, first_error encoding, AXI burst length width.
package munoc_axi_protocol_checker_pkg;

   localparam int unsigned BW_LEN      = 8;
   localparam int unsigned NUM_FLAGS   = 8;
   localparam int unsigned BW_FLAG_IDX = 3;

   localparam int unsigned FLAG_AW_STALL = 0;
   localparam int unsigned FLAG_W_STALL  = 1;
   localparam int unsigned FLAG_AR_STALL = 2;
   localparam int unsigned FLAG_WLAST    = 3;
   localparam int unsigned FLAG_RLAST    = 4;
   localparam int unsigned FLAG_WACCT    = 5;
   localparam int unsigned FLAG_RACCT    = 6;
   localparam int unsigned FLAG_STABLE   = 7;

   typedef struct packed {
      logic                   valid;
      logic [BW_FLAG_IDX-1:0] index;
   } first_error_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [BW_FLAG_IDX-1:0] lowest_flag(input logic [NUM_FLAGS-1:0] vec);
      logic [BW_FLAG_IDX-1:0] idx;
      idx = '0;
      for (int i = int'(NUM_FLAGS) - 1; i >= 0; i--) begin
         if (vec[i]) idx = BW_FLAG_IDX'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/munoc_axi_len_tracker.sv
// In-order burst length FIFO plus beat counter for one AXI data channel.
// Reports overflowing pushes, beats with no known burst, and last-beat mismatches.
module munoc_axi_len_tracker
   import munoc_axi_protocol_checker_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic              clk,
   input  logic              rstnn,
   input  logic              enable,
   input  logic              push,
   input  logic [BW_LEN-1:0] push_len,
   input  logic              beat,
   input  logic              last,
   output logic              overflow_c,
   output logic              orphan_c,
   output logic              mismatch_c,
   output logic              done_c
);

   localparam int unsigned BW_PTR = $clog2(DEPTH);
   localparam int unsigned BW_CNT = BW_PTR + 1;

   logic [BW_LEN-1:0] mem_q [DEPTH];
   logic [BW_PTR-1:0] wr_ptr_q, wr_ptr_d;
   logic [BW_PTR-1:0] rd_ptr_q, rd_ptr_d;
   logic [BW_CNT-1:0] count_q, count_d;
   logic [BW_LEN-1:0] beat_cnt_q, beat_cnt_d;
   logic [BW_LEN-1:0] head_len;
   logic              empty, full, push_ok, active;

   // A push in the same cycle as a beat on an empty FIFO bypasses straight to the head.
   always_comb begin
      empty      = (count_q == '0);
      full       = (count_q == BW_CNT'(DEPTH));
      push_ok    = push & ~full;
      active     = ~empty | push;
      head_len   = empty ? push_len : mem_q[rd_ptr_q];
      overflow_c = push & full;
      orphan_c   = beat & ~active;
      mismatch_c = beat & active & (last != (beat_cnt_q == head_len));
      done_c     = beat & active & last;

      wr_ptr_d   = push_ok ? wr_ptr_q + BW_PTR'(1) : wr_ptr_q;
      rd_ptr_d   = done_c ? rd_ptr_q + BW_PTR'(1) : rd_ptr_q;
      count_d    = count_q + BW_CNT'(push_ok) - BW_CNT'(done_c);
      beat_cnt_d = beat_cnt_q;
      if (done_c) begin
         beat_cnt_d = '0;
      end else if (beat & active) begin
         beat_cnt_d = beat_cnt_q + BW_LEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (enable && push_ok) mem_q[wr_ptr_q] <= push_len;
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         beat_cnt_q <= '0;
      end else if (enable) begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: rtl/munoc_axi_protocol_checker.sv
// Passive AXI protocol checker: stall timeouts, burst length/last, outstanding accounting.
// Optional valid/payload stability check enabled by MUNOC_AXI_CHECKER_STABILITY_CHECK_EN.
module munoc_axi_protocol_checker
   import munoc_axi_protocol_checker_pkg::*;
#(
   parameter int unsigned BW_ADDR         = 32,
   parameter int unsigned BW_DATA         = 32,
   parameter int unsigned BW_TIMEOUT      = 16,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                   clk,
   input  logic                   rstnn,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [BW_TIMEOUT-1:0]  cfg_timeout,
   input  logic                   awvalid,
   input  logic                   awready,
   input  logic [BW_LEN-1:0]      awlen,
   input  logic [BW_ADDR-1:0]     awaddr,
   input  logic                   arvalid,
   input  logic                   arready,
   input  logic [BW_LEN-1:0]      arlen,
   input  logic [BW_ADDR-1:0]     araddr,
   input  logic                   wvalid,
   input  logic                   wready,
   input  logic                   wlast,
   input  logic [BW_DATA/8-1:0]   wstrb,
   input  logic                   bvalid,
   input  logic                   bready,
   input  logic                   rvalid,
   input  logic                   rready,
   input  logic                   rlast,
   output logic [NUM_FLAGS-1:0]   error_flags,
   output logic [3:0]             first_error,
   output logic                   irq
);

   localparam int unsigned BW_STRB = BW_DATA / 8;
   localparam int unsigned BW_OST  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned BW_SUM  = BW_OST + 1;
   localparam logic [BW_OST-1:0] OST_MAX = '1;

   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [2:0]            stalled_c;
   logic [BW_TIMEOUT-1:0] stall_q   [3];
   logic [BW_TIMEOUT-1:0] stall_d   [3];
   logic [BW_TIMEOUT-1:0] stall_inc [3];
   logic [BW_OST-1:0]     b_pend_q, b_pend_d;
   logic [BW_OST-1:0]     rd_out_q, rd_out_d;
   logic [BW_SUM-1:0]     b_sum, rd_sum;
   logic                  b_underflow;
   logic [NUM_FLAGS-1:0]  err_c, flags_q, flags_d;
   first_error_t          first_q, first_d;
   logic                  w_overflow, w_orphan, w_mismatch, w_done;
   logic                  r_overflow, r_orphan, r_mismatch, r_done;
   logic                  stable_err_c;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign b_hs  = bvalid & bready;
   assign ar_hs = arvalid & arready;
   assign r_hs  = rvalid & rready;

   munoc_axi_len_tracker #(.DEPTH(MAX_OUTSTANDING)) u_w_track (
      .clk        (clk),
      .rstnn      (rstnn),
      .enable     (enable),
      .push       (aw_hs),
      .push_len   (awlen),
      .beat       (w_hs),
      .last       (wlast),
      .overflow_c (w_overflow),
      .orphan_c   (w_orphan),
      .mismatch_c (w_mismatch),
      .done_c     (w_done)
   );

   munoc_axi_len_tracker #(.DEPTH(MAX_OUTSTANDING)) u_r_track (
      .clk        (clk),
      .rstnn      (rstnn),
      .enable     (enable),
      .push       (ar_hs),
      .push_len   (arlen),
      .beat       (r_hs),
      .last       (rlast),
      .overflow_c (r_overflow),
      .orphan_c   (r_orphan),
      .mismatch_c (r_mismatch),
      .done_c     (r_done)
   );

   always_comb begin
      stalled_c = {arvalid & ~arready, wvalid & ~wready, awvalid & ~awready};
      err_c     = '0;
      for (int i = 0; i < 3; i++) begin
         stall_inc[i] = '0;
         if (stalled_c[i]) begin
            stall_inc[i] = (&stall_q[i]) ? stall_q[i] : stall_q[i] + BW_TIMEOUT'(1);
         end
         stall_d[i] = clear ? '0 : stall_inc[i];
         err_c[i]   = stalled_c[i] & (cfg_timeout != '0) & (stall_inc[i] == cfg_timeout);
      end

      // A B response may retire the burst completing in the same cycle.
      b_sum       = {1'b0, b_pend_q} + BW_SUM'(w_done);
      b_underflow = b_hs & (b_sum == '0);
      if (b_hs && !b_underflow) b_sum = b_sum - BW_SUM'(1);
      b_pend_d    = (b_sum > BW_SUM'(OST_MAX)) ? OST_MAX : b_sum[BW_OST-1:0];

      rd_sum = {1'b0, rd_out_q} + BW_SUM'(ar_hs);
      if (r_hs && rlast && (rd_sum != '0)) rd_sum = rd_sum - BW_SUM'(1);
      rd_out_d = (rd_sum > BW_SUM'(OST_MAX)) ? OST_MAX : rd_sum[BW_OST-1:0];

      err_c[FLAG_WLAST]  = w_mismatch | w_orphan;
      err_c[FLAG_RLAST]  = r_mismatch;
      err_c[FLAG_WACCT]  = w_overflow | b_underflow;
      err_c[FLAG_RACCT]  = r_overflow | r_orphan;
      err_c[FLAG_STABLE] = stable_err_c;

      flags_d = flags_q | err_c;
      first_d = first_q;
      if (!first_q.valid && (err_c != '0)) begin
         first_d.valid = 1'b1;
         first_d.index = lowest_flag(err_c);
      end
      if (clear) begin
         flags_d = '0;
         first_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         for (int i = 0; i < 3; i++) stall_q[i] <= '0;
         b_pend_q <= '0;
         rd_out_q <= '0;
         flags_q  <= '0;
         first_q  <= '0;
      end else if (enable) begin
         for (int i = 0; i < 3; i++) stall_q[i] <= stall_d[i];
         b_pend_q <= b_pend_d;
         rd_out_q <= rd_out_d;
         flags_q  <= flags_d;
         first_q  <= first_d;
      end
   end

   assign error_flags = flags_q;
   assign first_error = first_q;
   assign irq         = |flags_q;

`ifdef MUNOC_AXI_CHECKER_STABILITY_CHECK_EN
   logic [2:0]                hold_q, hold_d;
   logic [BW_ADDR+BW_LEN-1:0] aw_pl_q, aw_pl_d, ar_pl_q, ar_pl_d;
   logic [BW_STRB:0]          w_pl_q, w_pl_d;

   // A channel stalled last cycle must keep valid high and its payload unchanged.
   always_comb begin
      hold_d       = stalled_c;
      aw_pl_d      = {awaddr, awlen};
      w_pl_d       = {wstrb, wlast};
      ar_pl_d      = {araddr, arlen};
      stable_err_c = (hold_q[0] & (~awvalid | (aw_pl_d != aw_pl_q)))
                   | (hold_q[1] & (~wvalid  | (w_pl_d  != w_pl_q)))
                   | (hold_q[2] & (~arvalid | (ar_pl_d != ar_pl_q)));
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         hold_q  <= '0;
         aw_pl_q <= '0;
         w_pl_q  <= '0;
         ar_pl_q <= '0;
      end else if (enable) begin
         hold_q  <= hold_d;
         aw_pl_q <= aw_pl_d;
         w_pl_q  <= w_pl_d;
         ar_pl_q <= ar_pl_d;
      end
   end
`else
   logic unused_payload;
   assign unused_payload = ^{awaddr, araddr, wstrb};
   assign stable_err_c   = 1'b0;
`endif

endmodule

// File: tb/tb_munoc_axi_protocol_checker.sv
// Self-checking bench for munoc_axi_protocol_checker: directed scenarios plus a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_munoc_axi_protocol_checker;

   localparam int unsigned BW_ADDR    = 32;
   localparam int unsigned BW_DATA    = 32;
   localparam int unsigned BW_TIMEOUT = 16;
   localparam int unsigned MAXO       = 8;
   localparam int          STALL_MAX  = (1 << BW_TIMEOUT) - 1;
   localparam int          BMAX       = (1 << ($clog2(MAXO) + 1)) - 1;
`ifdef MUNOC_AXI_CHECKER_STABILITY_CHECK_EN
   localparam bit STAB = 1'b1;
`else
   localparam bit STAB = 1'b0;
`endif

   logic                  clk, rstnn, enable, clear;
   logic [BW_TIMEOUT-1:0] cfg_timeout;
   logic                  awvalid, awready, arvalid, arready;
   logic [7:0]            awlen, arlen;
   logic [BW_ADDR-1:0]    awaddr, araddr;
   logic                  wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;
   logic [BW_DATA/8-1:0]  wstrb;
   logic [7:0]            error_flags;
   logic [3:0]            first_error;
   logic                  irq;

   munoc_axi_protocol_checker #(
      .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_TIMEOUT(BW_TIMEOUT), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear), .cfg_timeout(cfg_timeout),
      .awvalid(awvalid), .awready(awready), .awlen(awlen), .awaddr(awaddr),
      .arvalid(arvalid), .arready(arready), .arlen(arlen), .araddr(araddr),
      .wvalid(wvalid), .wready(wready), .wlast(wlast), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
      .error_flags(error_flags), .first_error(first_error), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int           m_wq[$];
   int           m_rq[$];
   int           m_wbeat, m_rbeat, m_bpend;
   int           m_stall[3];
   bit [7:0]     m_flags;
   bit [3:0]     m_first;
   bit [2:0]     m_prev_st;
   logic [BW_ADDR-1:0] m_prev_awaddr, m_prev_araddr;
   logic [7:0]   m_prev_awlen, m_prev_arlen;
   logic [BW_DATA/8-1:0] m_prev_wstrb;
   logic         m_prev_wlast;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wq.delete();
      m_rq.delete();
      m_wbeat = 0; m_rbeat = 0; m_bpend = 0;
      for (int i = 0; i < 3; i++) m_stall[i] = 0;
      m_flags = '0; m_first = '0; m_prev_st = '0;
      m_prev_awaddr = '0; m_prev_araddr = '0; m_prev_awlen = '0; m_prev_arlen = '0;
      m_prev_wstrb = '0; m_prev_wlast = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit [7:0] e;
      bit [2:0] st;
      bit       wdone;
      int       p;
      int       idx;
      e = '0;
      wdone = 1'b0;
      if (!enable) return;
      st = {arvalid & ~arready, wvalid & ~wready, awvalid & ~awready};
      for (int i = 0; i < 3; i++) begin
         if (st[i]) begin
            if (m_stall[i] < STALL_MAX) m_stall[i]++;
            if (cfg_timeout != 0 && m_stall[i] == int'(cfg_timeout)) e[i] = 1'b1;
         end else begin
            m_stall[i] = 0;
         end
      end
      if (STAB) begin
         if (m_prev_st[0] && (!awvalid || awaddr != m_prev_awaddr || awlen != m_prev_awlen)) e[7] = 1'b1;
         if (m_prev_st[1] && (!wvalid || wstrb != m_prev_wstrb || wlast != m_prev_wlast)) e[7] = 1'b1;
         if (m_prev_st[2] && (!arvalid || araddr != m_prev_araddr || arlen != m_prev_arlen)) e[7] = 1'b1;
      end
      m_prev_st = st;
      m_prev_awaddr = awaddr; m_prev_awlen = awlen; m_prev_wstrb = wstrb; m_prev_wlast = wlast;
      m_prev_araddr = araddr; m_prev_arlen = arlen;

      if (awvalid && awready) begin
         if (m_wq.size() == MAXO) e[5] = 1'b1;
         else m_wq.push_back(int'(awlen));
      end
      if (wvalid && wready) begin
         if (m_wq.size() == 0) e[3] = 1'b1;
         else begin
            if (wlast != (m_wbeat == m_wq[0])) e[3] = 1'b1;
            if (wlast) begin
               void'(m_wq.pop_front());
               m_wbeat = 0;
               wdone = 1'b1;
            end else m_wbeat = (m_wbeat + 1) % 256;
         end
      end
      p = m_bpend + int'(wdone);
      if (bvalid && bready) begin
         if (p == 0) e[5] = 1'b1;
         else p--;
      end
      m_bpend = (p > BMAX) ? BMAX : p;

      if (arvalid && arready) begin
         if (m_rq.size() == MAXO) e[6] = 1'b1;
         else m_rq.push_back(int'(arlen));
      end
      if (rvalid && rready) begin
         if (m_rq.size() == 0) e[6] = 1'b1;
         else begin
            if (rlast != (m_rbeat == m_rq[0])) e[4] = 1'b1;
            if (rlast) begin
               void'(m_rq.pop_front());
               m_rbeat = 0;
            end else m_rbeat = (m_rbeat + 1) % 256;
         end
      end

      if (clear) begin
         m_flags = '0;
         m_first = '0;
         for (int i = 0; i < 3; i++) m_stall[i] = 0;
      end else begin
         if (!m_first[3] && e != 0) begin
            idx = 0;
            for (int i = 7; i >= 0; i--) if (e[i]) idx = i;
            m_first = {1'b1, 3'(idx)};
         end
         m_flags = m_flags | e;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_eq("error_flags", 32'(error_flags), 32'(m_flags));
      check_eq("first_error", 32'(first_error), 32'(m_first));
      check_eq("irq", 32'(irq), 32'(m_flags != 0));
   endtask

   task automatic idle();
      enable = 1'b1; clear = 1'b0;
      awvalid = 0; awready = 0; awlen = '0; awaddr = '0;
      arvalid = 0; arready = 0; arlen = '0; araddr = '0;
      wvalid = 0; wready = 0; wlast = 0; wstrb = '0;
      bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
   endtask

   task automatic do_reset();
      idle();
      rstnn = 1'b0;
      #1;
      check_eq("reset_flags", 32'(error_flags), 32'h0);
      check_eq("reset_first", 32'(first_error), 32'h0);
      check_eq("reset_irq", 32'(irq), 32'h0);
      @(posedge clk);
      #1;
      rstnn = 1'b1;
      model_reset();
   endtask

   task automatic rand_inputs(input int cyc);
      bit aw_hold, w_hold, ar_hold, exp_last;
      int tmo_tab[6] = '{0, 1, 2, 3, 5, 8};
      aw_hold = awvalid & ~awready;
      w_hold  = wvalid & ~wready;
      ar_hold = arvalid & ~arready;
      if (cyc % 250 == 0) cfg_timeout = BW_TIMEOUT'(tmo_tab[$urandom_range(0, 5)]);
      enable = ($urandom_range(0, 29) != 0);
      clear  = ($urandom_range(0, 24) == 0);

      if (aw_hold && $urandom_range(0, 19) != 0) begin
         if ($urandom_range(0, 29) == 0) awaddr = awaddr + 4;
      end else begin
         awvalid = ($urandom_range(0, 2) == 0);
         awaddr  = $urandom;
         awlen   = 8'($urandom_range(0, 3));
      end
      awready = ($urandom_range(0, 3) != 0);

      if (w_hold && $urandom_range(0, 19) != 0) begin
         if ($urandom_range(0, 29) == 0) wstrb = ~wstrb;
      end else begin
         wvalid = ($urandom_range(0, 1) == 0);
         wstrb  = 4'($urandom);
         if (m_wq.size() != 0) exp_last = (m_wbeat == m_wq[0]);
         else if (awvalid && awready) exp_last = (awlen == 0);
         else exp_last = 1'($urandom_range(0, 1));
         wlast = ($urandom_range(0, 9) != 0) ? exp_last : 1'($urandom_range(0, 1));
      end
      wready = ($urandom_range(0, 3) != 0);
      bvalid = ($urandom_range(0, 3) == 0);
      bready = 1'($urandom_range(0, 1));

      if (ar_hold && $urandom_range(0, 19) != 0) begin
         if ($urandom_range(0, 29) == 0) arlen = arlen + 8'd1;
      end else begin
         arvalid = ($urandom_range(0, 2) == 0);
         araddr  = $urandom;
         arlen   = 8'($urandom_range(0, 3));
      end
      arready = ($urandom_range(0, 3) != 0);
      rvalid  = ($urandom_range(0, 1) == 0);
      rready  = ($urandom_range(0, 3) != 0);
      if (m_rq.size() != 0) exp_last = (m_rbeat == m_rq[0]);
      else if (arvalid && arready) exp_last = (arlen == 0);
      else exp_last = 1'($urandom_range(0, 1));
      rlast = ($urandom_range(0, 9) != 0) ? exp_last : 1'($urandom_range(0, 1));
   endtask

   initial begin
      clk = 1'b0;
      rstnn = 1'b0;
      cfg_timeout = '0;
      idle();
      model_reset();

      // AW stall timeout
      do_reset();
      cfg_timeout = 16'd4;
      awvalid = 1; awready = 0; awaddr = 32'h40;
      repeat (3) step();
      check_eq("aw_stall_early", 32'(error_flags), 32'h00);
      step();
      check_eq("aw_stall_flag", 32'(error_flags), 32'h01);
      check_eq("aw_stall_first", 32'(first_error), 32'h8);
      check_eq("aw_stall_irq", 32'(irq), 32'h1);

      // Early wlast on a 4-beat burst
      do_reset();
      cfg_timeout = '0;
      awvalid = 1; awready = 1; awlen = 8'd3;
      step();
      awvalid = 0; wvalid = 1; wready = 1; wlast = 0;
      repeat (2) step();
      wlast = 1;
      step();
      check_eq("wlast_early_flag", 32'(error_flags), 32'h08);
      check_eq("wlast_early_first", 32'(first_error), 32'hB);

      // Correct burst, then one legal B and one surplus B
      do_reset();
      awvalid = 1; awready = 1; awlen = 8'd3;
      step();
      awvalid = 0; wvalid = 1; wready = 1; wlast = 0;
      repeat (3) step();
      wlast = 1;
      step();
      check_eq("wlast_ok_flag", 32'(error_flags), 32'h00);
      wvalid = 0; wlast = 0; bvalid = 1; bready = 1;
      step();
      check_eq("b_pending_one", 32'(error_flags), 32'h00);
      step();
      check_eq("b_surplus_flag", 32'(error_flags), 32'h20);

      // Write FIFO overflow, then B with nothing pending
      do_reset();
      awvalid = 1; awready = 1;
      for (int i = 0; i < 8; i++) begin
         awlen = 8'(i);
         step();
      end
      check_eq("aw_fill_ok", 32'(error_flags), 32'h00);
      step();
      check_eq("aw_overflow_flag", 32'(error_flags), 32'h20);
      check_eq("aw_overflow_first", 32'(first_error), 32'hD);
      awvalid = 0; bvalid = 1; bready = 1;
      step();
      check_eq("b_underflow_sticky", 32'(error_flags), 32'h20);
      bvalid = 0; clear = 1;
      step();
      check_eq("clear_flags", 32'(error_flags), 32'h00);
      clear = 0; bvalid = 1;
      step();
      check_eq("b_still_zero", 32'(error_flags), 32'h20);

      // Read side: bypass, orphan beat, clear beating a new error
      do_reset();
      arvalid = 1; arready = 1; arlen = 8'd0; rvalid = 1; rready = 1; rlast = 1;
      step();
      check_eq("r_bypass_ok", 32'(error_flags), 32'h00);
      arvalid = 0; rlast = 0;
      step();
      check_eq("r_orphan_flag", 32'(error_flags), 32'h40);
      check_eq("r_orphan_first", 32'(first_error), 32'hE);
      arvalid = 1; arlen = 8'd1; rlast = 1; clear = 1;
      step();
      check_eq("clear_wins_flags", 32'(error_flags), 32'h00);
      check_eq("clear_wins_first", 32'(first_error), 32'h0);
      clear = 0; arvalid = 0; rvalid = 0;
      step();
      arvalid = 1; arlen = 8'd0; rvalid = 1; rlast = 0;
      step();
      check_eq("rlast_missing_flag", 32'(error_flags), 32'h10);
      check_eq("rlast_missing_first", 32'(first_error), 32'hC);

      // Payload change while stalled
      do_reset();
      awvalid = 1; awready = 0; awaddr = 32'h100;
      step();
      awaddr = 32'h104;
      step();
      check_eq("stab_bit7", 32'(error_flags[7]), 32'(STAB));

      // Asynchronous reset mid-burst
      do_reset();
      awvalid = 1; awready = 1; awlen = 8'd3;
      step();
      awvalid = 0; wvalid = 1; wready = 1; wlast = 0;
      step();
      wvalid = 0; bvalid = 1; bready = 1;
      step();
      check_eq("pre_rst_flags", 32'(error_flags), 32'h20);
      bvalid = 0;
      #3;
      rstnn = 1'b0;
      #1;
      check_eq("async_rst_flags", 32'(error_flags), 32'h0);
      check_eq("async_rst_first", 32'(first_error), 32'h0);
      check_eq("async_rst_irq", 32'(irq), 32'h0);
      #2;
      rstnn = 1'b1;
      model_reset();
      idle();
      wvalid = 1; wready = 1; wlast = 1;
      step();
      check_eq("post_rst_w_orphan", 32'(error_flags), 32'h08);

      // Randomized run against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_inputs(c);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
